// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
//   Bundles the three channels of the ALU command sequencer:
//     cmd_*  : request channel (valid/ready), operands are 2*W bits wide
//     alu_*  : drive/capture of a purely combinational W-bit ALU
//     rsp_*  : result channel (valid/ready), result is 2*W bits wide
//   Modports:
//     slave  : the sequencer (accepts commands, drives the ALU, returns results)
//     master : the environment (issues commands, models the ALU, takes results)
//   Optional: ALU_OP_SEQUENCER_ZFLAG_EN adds rsp_zero to the result channel.
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_fs;
  logic [2*W-1:0]   cmd_a;
  logic [2*W-1:0]   cmd_b;
  logic             cmd_cin;
  logic             cmd_wide;

  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [4:0]       alu_fs;
  logic             alu_cin;
  logic [W-1:0]     alu_f;
  logic             alu_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_f;
  logic             rsp_cout;
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
  logic             rsp_zero;
`endif

  modport slave (
    input  cmd_valid, cmd_fs, cmd_a, cmd_b, cmd_cin, cmd_wide,
    output cmd_ready,
    output alu_a, alu_b, alu_fs, alu_cin,
    input  alu_f, alu_cout,
    output rsp_valid, rsp_f, rsp_cout,
    input  rsp_ready
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
    , output rsp_zero
`endif
  );

  modport master (
    output cmd_valid, cmd_fs, cmd_a, cmd_b, cmd_cin, cmd_wide,
    input  cmd_ready,
    input  alu_a, alu_b, alu_fs, alu_cin,
    output alu_f, alu_cout,
    input  rsp_valid, rsp_f, rsp_cout,
    output rsp_ready
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
    , input rsp_zero
`endif
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Command-side driver for a W-bit combinational ALU. A request is accepted
//   in IDLE, its operands are registered, and the ALU is run for one pass
//   (narrow) or two passes, low half then high half (wide). F/Cout are
//   captured in the same cycle they are driven and returned on the response
//   channel, held stable until the consumer takes them.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : alu_op_sequencer_if.slave (cmd_*, alu_*, rsp_* channels)
//   Parameters:
//     W          : ALU width; results are 2*W bits
//     CHAIN_MASK : bit i set -> FS=i feeds the low-pass Cout into the
//                  high-pass Cin; clear -> high pass reuses cmd_cin
//   Optional feature macro: ALU_OP_SEQUENCER_ZFLAG_EN (adds rsp_zero).
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int          W          = 16,
  parameter logic [31:0] CHAIN_MASK = 32'h0000_FFFF
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

  state_e         state_q, state_d;
  logic [4:0]     fs_q, fs_d;
  logic [2*W-1:0] a_q, a_d;
  logic [2*W-1:0] b_q, b_d;
  logic           cin_q, cin_d;
  logic           wide_q, wide_d;
  logic [2*W-1:0] res_q, res_d;
  logic           carry_q, carry_d;
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
  logic           zero_q, zero_d;
`endif

  logic           cmd_ready;
  logic           rsp_valid;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [4:0]     alu_fs;
  logic           alu_cin;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fs_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      wide_q  <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fs_q    <= fs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      wide_q  <= wide_d;
      res_q   <= res_d;
      carry_q <= carry_d;
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    fs_d      = fs_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    wide_d    = wide_q;
    res_d     = res_q;
    carry_d   = carry_q;
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
    zero_d    = zero_q;
`endif
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_fs    = '0;
    alu_cin   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Reset overrides the accept so nothing is taken during reset.
        cmd_ready = !rst;
        if (bus.cmd_valid && cmd_ready) begin
          fs_d    = bus.cmd_fs;
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          cin_d   = bus.cmd_cin;
          wide_d  = bus.cmd_wide;
          state_d = LO;
        end
      end

      LO: begin
        alu_a   = a_q[W-1:0];
        alu_b   = b_q[W-1:0];
        alu_fs  = fs_q;
        alu_cin = cin_q;
        res_d[W-1:0] = bus.alu_f;
        carry_d      = bus.alu_cout;
        if (wide_q) begin
          state_d = HI;
        end else begin
          res_d[2*W-1:W] = '0;
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
          zero_d = (bus.alu_f == '0);
`endif
          state_d = RESP;
        end
      end

      HI: begin
        alu_a   = a_q[2*W-1:W];
        alu_b   = b_q[2*W-1:W];
        alu_fs  = fs_q;
        alu_cin = CHAIN_MASK[fs_q] ? carry_q : cin_q;
        res_d[2*W-1:W] = bus.alu_f;
        carry_d        = bus.alu_cout;
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
        zero_d = ({bus.alu_f, res_q[W-1:0]} == '0);
`endif
        state_d = RESP;
      end

      RESP: begin
        rsp_valid = !rst;
        if (bus.rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_f     = res_q;
  assign bus.rsp_cout  = carry_q;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_fs    = alu_fs;
  assign bus.alu_cin   = alu_cin;
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
  assign bus.rsp_zero  = zero_q;
`endif

endmodule
